fwd_pipe_exec: RTL and testbench
================================

Name: fwd_pipe_exec

Overview:
- Parametrised three-stage execute pipeline (operand fetch, EX, WB) with its own register file.
- Full EX→operand forwarding, so back-to-back dependent instructions run without nops or stalls.
- Valid/ready handshake on both sides, plus a retire counter.
- Sits between the decoder/control unit (upstream) and the CPU's writeback/monitor logic (downstream).

Parameters:
- WIDTH, 16, datapath and register width (≥4, even).
- RA_W, 2, register address width; register file has 2^RA_W entries; entry 0 reads as zero.
- CNT_W, 16, retire counter width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  instruction present.
- in_ready  out  1  pipeline can accept an instruction this cycle.
- in_op  in  3  ALU control: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; any other code executes as ADD.
- in_rs  in  RA_W  source A register.
- in_rt  in  RA_W  source B register.
- in_rd  in  RA_W  destination register.
- in_imm  in  WIDTH/2  immediate, sign-extended to WIDTH.
- in_use_imm  in  1  1 selects the immediate for operand B.
- in_wen  in  1  instruction writes in_rd.
- out_valid  out  1  retiring instruction present.
- out_ready  in  1  downstream accepts the retiring instruction.
- out_rd  out  RA_W  destination of the retiring instruction.
- out_data  out  WIDTH  result of the retiring instruction.
- out_zero  out  1  out_data == 0.
- out_ovf  out  1  signed overflow of ADD/SUB; 0 for all other ops.
- retired  out  CNT_W  count of instructions retired.

Behaviour:
- **Stages.**
  - S1 register holds the accepted instruction plus its regfile-read operands.
  - S2 register holds the computed result, rd, wen, zero and ovf.
  - Regfile write occurs as S2 retires.
- **Advance.** Pipeline advances when `adv = !(S2.valid & !out_ready)`. `in_ready = adv`.
- **Accept.** An instruction is accepted on an edge where in_valid & in_ready. A bubble enters S1 when in_valid=0 and adv=1. Under !adv, S1 and S2 hold.
- **Latency.**
  - Instruction accepted at edge t: out_valid during cycle t+2 when out_ready stays 1.
  - Register written at edge t+2, on the retiring handshake out_valid & out_ready.
  - Throughput is one per cycle.
- **Forwarding.** Operands are read in EX from the S1 instruction's rs/rt.
  - If S2.valid & S2.wen & S2.rd == src & src != 0, the operand is S2 result.
  - Otherwise the operand is the regfile value.
  - Any rs/rt equal to 0 yields 0.
  - No stall is ever needed for data hazards.
- **Write rules.**
  - Writes to register 0 are discarded.
  - A write occurs only on the retire handshake with wen=1.
- **Arithmetic.**
  - Results are modulo 2^WIDTH.
  - SUB is a + ~b + 1.
  - SLT is a signed compare; result 1 or 0, zero-extended.
  - ovf = (a[MSB] == b'[MSB]) & (sum[MSB] != a[MSB]), where b' is the inverted b for SUB.
- **Retire counter.** `retired` increments on each out_valid & out_ready handshake and wraps at 2^CNT_W.
- **Reset (rst_n=0 at a rising edge).**
  - S1.valid = S2.valid = 0; all regfile entries = 0; retired = 0.
  - out_valid = 0; out_data = 0; out_rd = 0; out_zero = 0; out_ovf = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset mid-operation discards in-flight instructions with no regfile write. Reset has priority over a simultaneous handshake.
- **Simultaneous events.** Retire-write and accept on the same edge are both performed.

Test Plan:
- **Back-to-back dependent program, no nops.** Stimulus, one per cycle:
  - addi r1,r0,15
  - addi r2,r0,7
  - and r3,r1,r2
  - sub r2,r1,r3
  - or r2,r2,r3
  - add r3,r2,r3
  - slt r1,r3,r2
  - slt r1,r2,r3

  Required out_data sequence: 15, 7, 7, 8, 15, 22, 0, 1. retired = 8.
- **Backpressure.** Hold out_ready=0 for 3 cycles with S2 holding addi r1=5.
  - out_valid stays 1 with out_data=5 throughout; in_ready=0.
  - The following add r2,r1,r1 then retires with 10.
- **Register 0.** addi r0,r0,9 then add r1,r0,r0 → first out_data=9, second out_data=0 (no forward from r0).
- **Overflow and zero.**
  - 0x7FFF + 1 (WIDTH=16) → out_data=0x8000, out_ovf=1.
  - sub r2,r1,r1 → out_data=0, out_zero=1, out_ovf=0.
- **Mid-stream reset.** Assert rst_n=0 for one edge with two instructions in flight.
  - out_valid=0 next cycle; retired=0.
  - A subsequent add r1,r1,r1 returns 0, proving no write occurred.
- **Parameter sweep.** WIDTH=8, RA_W=3: addi r7,r0,-1 → out_data=0xFF; slt r6,r7,r0 → 1.

Source files
------------

// File: rtl/fwd_pipe_exec.sv
// Three-stage execute pipeline (fetch/EX/WB) with private regfile and full EX->operand forwarding.
// Latency: accepted at edge t, result presented during cycle t+2; one instruction per cycle.
// Backpressure: out_ready=0 with a valid result freezes S1 and S2 and drops in_ready.
module fwd_pipe_exec #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [RA_W-1:0]      in_rs,
    input  logic [RA_W-1:0]      in_rt,
    input  logic [RA_W-1:0]      in_rd,
    input  logic [WIDTH/2-1:0]   in_imm,
    input  logic                 in_use_imm,
    input  logic                 in_wen,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RA_W-1:0]      out_rd,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_zero,
    output logic                 out_ovf,
    output logic [CNT_W-1:0]     retired
);
    localparam int NREG = 1 << RA_W;
    localparam int HW   = WIDTH / 2;
    localparam int MSB  = WIDTH - 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // S1: accepted instruction; operands are resolved in EX so forwarding sees the latest S2 result
    logic                r_s1_vld;
    logic [2:0]          r_s1_op;
    logic [RA_W-1:0]     r_s1_rs;
    logic [RA_W-1:0]     r_s1_rt;
    logic [RA_W-1:0]     r_s1_rd;
    logic [HW-1:0]       r_s1_imm;
    logic                r_s1_use_imm;
    logic                r_s1_wen;

    // S2: computed result waiting to retire
    logic                r_s2_vld;
    logic [RA_W-1:0]     r_s2_rd;
    logic                r_s2_wen;
    logic [WIDTH-1:0]    r_s2_data;
    logic                r_s2_zero;
    logic                r_s2_ovf;

    logic [WIDTH-1:0]    r_rf [NREG];
    logic [CNT_W-1:0]    r_retired;

    logic                w_adv;
    logic                w_retire;
    logic [WIDTH-1:0]    w_op_a;
    logic [WIDTH-1:0]    w_op_rt;
    logic [WIDTH-1:0]    w_op_b;
    logic [WIDTH-1:0]    w_b_eff;
    logic                w_cin;
    logic [WIDTH-1:0]    w_sum;
    logic                w_add_ovf;
    logic [WIDTH-1:0]    w_res;
    logic                w_ovf;

    // The whole pipe moves unless a valid result is stuck at the output
    assign w_adv    = !(r_s2_vld && !out_ready);
    assign w_retire = r_s2_vld && out_ready;
    assign in_ready = w_adv;

    // Operand selection: register 0 is hard zero, otherwise S2 result beats the regfile
    always_comb begin
        w_op_a  = '0;
        w_op_rt = '0;
        if (r_s1_rs != '0) begin
            if (r_s2_vld && r_s2_wen && (r_s2_rd == r_s1_rs)) w_op_a = r_s2_data;
            else                                              w_op_a = r_rf[r_s1_rs];
        end
        if (r_s1_rt != '0) begin
            if (r_s2_vld && r_s2_wen && (r_s2_rd == r_s1_rt)) w_op_rt = r_s2_data;
            else                                              w_op_rt = r_rf[r_s1_rt];
        end
        w_op_b = r_s1_use_imm ? {{(WIDTH - HW){r_s1_imm[HW-1]}}, r_s1_imm} : w_op_rt;
    end

    // ALU: SUB shares the adder via inverted B plus carry-in; unknown codes fall through to ADD
    always_comb begin
        w_cin     = (r_s1_op == OP_SUB);
        w_b_eff   = w_cin ? ~w_op_b : w_op_b;
        w_sum     = w_op_a + w_b_eff + {{(WIDTH-1){1'b0}}, w_cin};
        w_add_ovf = (w_op_a[MSB] == w_b_eff[MSB]) && (w_sum[MSB] != w_op_a[MSB]);
        w_res     = w_sum;
        w_ovf     = w_add_ovf;
        case (r_s1_op)
            OP_AND: begin w_res = w_op_a & w_op_b; w_ovf = 1'b0; end
            OP_OR:  begin w_res = w_op_a | w_op_b; w_ovf = 1'b0; end
            OP_SLT: begin
                w_res    = '0;
                w_res[0] = ($signed(w_op_a) < $signed(w_op_b));
                w_ovf    = 1'b0;
            end
            default: ;
        endcase
    end

    // S1 register: loads a new instruction or a bubble whenever the pipe advances
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld     <= 1'b0;
            r_s1_op      <= '0;
            r_s1_rs      <= '0;
            r_s1_rt      <= '0;
            r_s1_rd      <= '0;
            r_s1_imm     <= '0;
            r_s1_use_imm <= 1'b0;
            r_s1_wen     <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld     <= in_valid;
            r_s1_op      <= in_op;
            r_s1_rs      <= in_rs;
            r_s1_rt      <= in_rt;
            r_s1_rd      <= in_rd;
            r_s1_imm     <= in_imm;
            r_s1_use_imm <= in_use_imm;
            r_s1_wen     <= in_wen;
        end
    end

    // S2 register: captures the EX result when the pipe advances
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_rd   <= '0;
            r_s2_wen  <= 1'b0;
            r_s2_data <= '0;
            r_s2_zero <= 1'b0;
            r_s2_ovf  <= 1'b0;
        end else if (w_adv) begin
            r_s2_vld  <= r_s1_vld;
            r_s2_rd   <= r_s1_rd;
            r_s2_wen  <= r_s1_wen;
            r_s2_data <= w_res;
            r_s2_zero <= (w_res == '0);
            r_s2_ovf  <= w_ovf;
        end
    end

    // Register file write on the retire handshake; register 0 never changes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (w_retire && r_s2_wen && (r_s2_rd != '0)) begin
            r_rf[r_s2_rd] <= r_s2_data;
        end
    end

    // Retire counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!rst_n)        r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + 1'b1;
    end

    assign out_valid = r_s2_vld;
    assign out_rd    = r_s2_rd;
    assign out_data  = r_s2_data;
    assign out_zero  = r_s2_zero;
    assign out_ovf   = r_s2_ovf;
    assign retired   = r_retired;

endmodule

// File: tb/tb_fwd_pipe_exec.sv
// Directed bench for fwd_pipe_exec: default instance plus a WIDTH=8/RA_W=3 instance.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Retiring results are collected on the falling edge into queues for in-order checks.
module tb_fwd_pipe_exec;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_use_imm, in_wen;
    logic [2:0]  in_op;
    logic [1:0]  in_rs, in_rt, in_rd;
    logic [7:0]  in_imm;
    logic        out_valid, out_ready, out_zero, out_ovf;
    logic [1:0]  out_rd;
    logic [15:0] out_data;
    logic [15:0] retired;

    logic        d2_in_valid, d2_in_ready, d2_in_use_imm, d2_in_wen;
    logic [2:0]  d2_in_op;
    logic [2:0]  d2_in_rs, d2_in_rt, d2_in_rd;
    logic [3:0]  d2_in_imm;
    logic        d2_out_valid, d2_out_ready, d2_out_zero, d2_out_ovf;
    logic [2:0]  d2_out_rd;
    logic [7:0]  d2_out_data;
    logic [7:0]  d2_retired;

    int errors = 0;
    int checks = 0;

    logic [15:0] q_dat[$];
    logic        q_ovf[$];
    logic        q_zero[$];

    always #5 clk = ~clk;

    fwd_pipe_exec #(.WIDTH(16), .RA_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_wen(in_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_data(out_data), .out_zero(out_zero), .out_ovf(out_ovf),
        .retired(retired)
    );

    fwd_pipe_exec #(.WIDTH(8), .RA_W(3), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_op(d2_in_op),
        .in_rs(d2_in_rs), .in_rt(d2_in_rt), .in_rd(d2_in_rd), .in_imm(d2_in_imm),
        .in_use_imm(d2_in_use_imm), .in_wen(d2_in_wen),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_rd(d2_out_rd),
        .out_data(d2_out_data), .out_zero(d2_out_zero), .out_ovf(d2_out_ovf),
        .retired(d2_retired)
    );

    // Collect every retiring result of the 16-bit instance
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            q_dat.push_back(out_data);
            q_ovf.push_back(out_ovf);
            q_zero.push_back(out_zero);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] rs,
                         input logic [1:0] rt, input logic [1:0] rd, input logic [7:0] imm,
                         input logic ui, input logic wen);
        in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_use_imm = ui; in_wen = wen;
    endtask

    task automatic idle();
        drive(1'b0, OP_ADD, 2'd0, 2'd0, 2'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        q_dat.delete(); q_ovf.delete(); q_zero.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        out_ready = 1'b1;
        d2_in_valid = 1'b0; d2_in_op = OP_ADD; d2_in_rs = '0; d2_in_rt = '0; d2_in_rd = '0;
        d2_in_imm = '0; d2_in_use_imm = 1'b0; d2_in_wen = 1'b0; d2_out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0h expected 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rst_out_data: got %0h expected 0", out_data); end
        checks++; if (out_rd !== 2'd0) begin errors++; $display("FAIL rst_out_rd: got %0h expected 0", out_rd); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL rst_out_zero: got %0h expected 0", out_zero); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL rst_out_ovf: got %0h expected 0", out_ovf); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL rst_retired: got %0d expected 0", retired); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0h expected 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d [8] = '{16'd15, 16'd7, 16'd7, 16'd8, 16'd15, 16'd22, 16'd0, 16'd1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd1, 8'd15, 1'b1, 1'b1);
                1: drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd2, 8'd7,  1'b1, 1'b1);
                2: drive(1'b1, OP_AND, 2'd1, 2'd2, 2'd3, 8'd0,  1'b0, 1'b1);
                3: drive(1'b1, OP_SUB, 2'd1, 2'd3, 2'd2, 8'd0,  1'b0, 1'b1);
                4: drive(1'b1, OP_OR,  2'd2, 2'd3, 2'd2, 8'd0,  1'b0, 1'b1);
                5: drive(1'b1, OP_ADD, 2'd2, 2'd3, 2'd3, 8'd0,  1'b0, 1'b1);
                6: drive(1'b1, OP_SLT, 2'd3, 2'd2, 2'd1, 8'd0,  1'b0, 1'b1);
                default: drive(1'b1, OP_SLT, 2'd2, 2'd3, 2'd1, 8'd0, 1'b0, 1'b1);
            endcase
            step();
            if (i == 0) begin
                @(negedge clk);
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %0h expected 0", out_valid); end
            end
            if (i == 1) begin
                @(negedge clk);
                checks++; if (out_valid !== 1'b1 || out_data !== 16'd15) begin
                    errors++; $display("FAIL lat_first_result: got valid=%0h data=%0d expected valid=1 data=15", out_valid, out_data);
                end
            end
        end
        idle();
        step(); step(); step();
        @(negedge clk);
        checks++; if (q_dat.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", q_dat.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= q_dat.size()) begin
                errors++; $display("FAIL b2b_data[%0d]: got none expected %0d", i, exp_d[i]);
            end else if (q_dat[i] !== exp_d[i]) begin
                errors++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, q_dat[i], exp_d[i]);
            end
        end
        checks++; if (retired !== 16'd8) begin errors++; $display("FAIL b2b_retired: got %0d expected 8", retired); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd1, 8'd5, 1'b1, 1'b1);
        step();
        drive(1'b1, OP_ADD, 2'd1, 2'd1, 2'd2, 8'd0, 1'b0, 1'b1);
        step();
        idle();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0h expected 1", c, out_valid); end
            checks++; if (out_data !== 16'd5) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected 5", c, out_data); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0h expected 0", c, in_ready); end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_data !== 16'd5 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got data=%0d rdy=%0h expected data=5 rdy=1", out_data, in_ready);
        end
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd10) begin
            errors++; $display("FAIL bp_dependent: got valid=%0h data=%0d expected valid=1 data=10", out_valid, out_data);
        end
        step();
        checks++; if (retired !== 16'd2) begin errors++; $display("FAIL bp_retired: got %0d expected 2", retired); end
    endtask

    task automatic test_reg_zero();
        do_reset();
        drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 8'd9, 1'b1, 1'b1);
        step();
        drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd1, 8'd0, 1'b0, 1'b1);
        step();
        idle();
        @(negedge clk);
        checks++; if (out_data !== 16'd9) begin errors++; $display("FAIL r0_first: got %0d expected 9", out_data); end
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd0) begin
            errors++; $display("FAIL r0_no_forward: got valid=%0h data=%0d expected valid=1 data=0", out_valid, out_data);
        end
        step();
    endtask

    task automatic test_ovf_zero();
        do_reset();
        drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd1, 8'd64, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, OP_ADD, 2'd1, 2'd1, 2'd1, 8'd0, 1'b0, 1'b1);
            step();
        end
        drive(1'b1, OP_ADD, 2'd1, 2'd0, 2'd2, 8'hFF, 1'b1, 1'b1);
        step();
        drive(1'b1, OP_ADD, 2'd2, 2'd1, 2'd2, 8'd0, 1'b0, 1'b1);
        step();
        drive(1'b1, OP_ADD, 2'd2, 2'd0, 2'd3, 8'd1, 1'b1, 1'b1);
        step();
        drive(1'b1, OP_SUB, 2'd1, 2'd1, 2'd2, 8'd0, 1'b0, 1'b1);
        step();
        idle();
        step(); step(); step();
        @(negedge clk);
        checks++; if (q_dat.size() != 13) begin
            errors++; $display("FAIL ovf_count: got %0d expected 13", q_dat.size());
        end else begin
            checks++; if (q_dat[8] !== 16'h4000) begin errors++; $display("FAIL ovf_build: got %0h expected 4000", q_dat[8]); end
            checks++; if (q_dat[10] !== 16'h7FFF || q_ovf[10] !== 1'b0) begin
                errors++; $display("FAIL ovf_7fff: got %0h ovf=%0h expected 7fff ovf=0", q_dat[10], q_ovf[10]);
            end
            checks++; if (q_dat[11] !== 16'h8000) begin errors++; $display("FAIL ovf_sum: got %0h expected 8000", q_dat[11]); end
            checks++; if (q_ovf[11] !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0h expected 1", q_ovf[11]); end
            checks++; if (q_zero[11] !== 1'b0) begin errors++; $display("FAIL ovf_zero: got %0h expected 0", q_zero[11]); end
            checks++; if (q_dat[12] !== 16'h0 || q_zero[12] !== 1'b1 || q_ovf[12] !== 1'b0) begin
                errors++; $display("FAIL sub_zero: got %0h z=%0h o=%0h expected 0 z=1 o=0", q_dat[12], q_zero[12], q_ovf[12]);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd1, 8'd5, 1'b1, 1'b1);
        step();
        drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd2, 8'd3, 1'b1, 1'b1);
        step();
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0h expected 0", out_valid); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL mid_rst_retired: got %0d expected 0", retired); end
        checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL mid_rst_data: got %0h expected 0", out_data); end
        drive(1'b1, OP_ADD, 2'd1, 2'd1, 2'd1, 8'd0, 1'b0, 1'b1);
        step();
        drive(1'b1, OP_ADD, 2'd2, 2'd2, 2'd3, 8'd0, 1'b0, 1'b1);
        step();
        idle();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd0) begin
            errors++; $display("FAIL mid_rst_r1: got valid=%0h data=%0d expected valid=1 data=0", out_valid, out_data);
        end
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd0) begin
            errors++; $display("FAIL mid_rst_r2: got valid=%0h data=%0d expected valid=1 data=0", out_valid, out_data);
        end
        step();
    endtask

    task automatic test_param_sweep();
        do_reset();
        d2_in_valid = 1'b1; d2_in_op = OP_ADD; d2_in_rs = 3'd0; d2_in_rt = 3'd0;
        d2_in_rd = 3'd7; d2_in_imm = 4'hF; d2_in_use_imm = 1'b1; d2_in_wen = 1'b1;
        step();
        d2_in_op = OP_SLT; d2_in_rs = 3'd7; d2_in_rt = 3'd0; d2_in_rd = 3'd6;
        d2_in_imm = 4'h0; d2_in_use_imm = 1'b0;
        step();
        d2_in_valid = 1'b0; d2_in_wen = 1'b0;
        @(negedge clk);
        checks++; if (d2_out_valid !== 1'b1 || d2_out_data !== 8'hFF) begin
            errors++; $display("FAIL w8_addi: got valid=%0h data=%0h expected valid=1 data=ff", d2_out_valid, d2_out_data);
        end
        step();
        @(negedge clk);
        checks++; if (d2_out_valid !== 1'b1 || d2_out_data !== 8'h01) begin
            errors++; $display("FAIL w8_slt: got valid=%0h data=%0h expected valid=1 data=1", d2_out_valid, d2_out_data);
        end
        step();
        checks++; if (d2_retired !== 8'd2) begin errors++; $display("FAIL w8_retired: got %0d expected 2", d2_retired); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_reg_zero();
        test_ovf_zero();
        test_mid_reset();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
